// File: rtl/seg7_pkg.sv
// Package: seg7_pkg
// Shared constants and helpers for the multiplexed 7-segment driver.
//   SEG_x_BIT   : bit positions of segments a..g and the decimal point
//   SEG_OFF     : active-high pattern with every segment dark
//   SEG_DASH    : active-high pattern for a dash (segment g only)
//   seg_lut()   : BCD digit -> active-high segment pattern (dp bit clear)
//   pow10()     : 10**n as a 64-bit constant, used for overflow limits
package seg7_pkg;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_OFF  = 8'h00;
    localparam logic [7:0] SEG_DASH = 8'h40;

    function automatic logic [7:0] seg_lut(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'h3F;
            4'd1:    p = 8'h06;
            4'd2:    p = 8'h5B;
            4'd3:    p = 8'h4F;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'h6D;
            4'd6:    p = 8'h7D;
            4'd7:    p = 8'h07;
            4'd8:    p = 8'h7F;
            4'd9:    p = 8'h6F;
            default: p = SEG_OFF;
        endcase
        return p;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Module: bin2bcd_seq
// Sequential double-dabble converter, one shift/add-3 step per clock.
//   CLK, RST  : clock, asynchronous active-high reset
//   start     : capture value and begin conversion (ignored while busy)
//   value     : unsigned binary input
//   busy      : conversion in progress (high from the capture edge)
//   done      : high during the last busy cycle; bcd/overflow are final then
//   bcd       : DIGITS packed BCD digits, digit 0 in bits [3:0]
//   overflow  : captured value did not fit in DIGITS decimal digits
// A conversion occupies WIDTH+1 cycles: one capture edge, WIDTH step edges,
// and a final edge where the consumer latches the result and busy drops.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int          CW    = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    logic [WIDTH-1:0]    shift_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [CW-1:0]       cnt_r;
    logic                busy_r;
    logic                ovf_r;
    logic [4*DIGITS-1:0] adj_s;
    logic [4*DIGITS-1:0] step_s;

    // Add-3 correction on every BCD nibble >= 5, then shift in the next binary bit.
    // Digits shifted past the top nibble are only lost on overflow, where the
    // digits are not displayed anyway.
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        step_s = {adj_s[4*DIGITS-2:0], shift_r[WIDTH-1]};
    end

    // Conversion sequencer: capture, WIDTH steps, then release busy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_r <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (!busy_r) begin
            if (start) begin
                shift_r <= value;
                bcd_r   <= '0;
                cnt_r   <= '0;
                busy_r  <= 1'b1;
                ovf_r   <= (64'(value) >= LIMIT);
            end
        end else if (cnt_r == CW'(WIDTH)) begin
            busy_r <= 1'b0;
        end else begin
            bcd_r   <= step_s;
            shift_r <= shift_r << 1;
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    assign busy     = busy_r;
    assign done     = busy_r && (cnt_r == CW'(WIDTH));
    assign bcd      = bcd_r;
    assign overflow = ovf_r;

endmodule

// File: rtl/seg7_scan_display.sv
// Module: seg7_scan_display
// Multiplexed 7-segment driver: binary value -> DIGITS decimal digits shown
// one at a time on a shared segment bus.
//   CLK, RST  : clock, asynchronous active-high reset
//   value     : unsigned binary value, sampled on load
//   load      : start a conversion (ignored while busy)
//   dp        : per-digit decimal point, bit0 = rightmost, sampled live
//   blank_lz  : blank leading zeros, sampled live
//   busy      : conversion in progress
//   overflow  : displayed value >= 10**DIGITS, all digits show a dash
//   segs      : bit0..6 = a..g, bit7 = dp, registered, polarity SEG_ACTIVE_LOW
//   digit_en  : one-hot digit select, registered, polarity DIG_ACTIVE_LOW
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int WIDTH          = 16,
    parameter int SCAN_DIV       = 16000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic [DIGITS-1:0] dp,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        segs,
    output logic [DIGITS-1:0] digit_en
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [7:0]        SEG_PIN_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] DIG_PIN_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] conv_bcd_s;
    logic                conv_ovf_s;
    logic                conv_done_s;
    logic                conv_busy_s;

    logic [4*DIGITS-1:0] disp_r;
    logic                ovf_r;
    logic [PW-1:0]       presc_r;
    logic [IW-1:0]       idx_r;
    logic [7:0]          segs_r;
    logic [DIGITS-1:0]   digit_en_r;

    logic [PW-1:0]       presc_nxt_s;
    logic [IW-1:0]       idx_nxt_s;
    logic [7:0]          pat_s [DIGITS];
    logic [3:0]          dig_val_s;
    logic                nz_above_s;
    logic [7:0]          sel_pat_s;
    logic [DIGITS-1:0]   dig_sel_s;
    logic [7:0]          segs_nxt_s;
    logic [DIGITS-1:0]   digit_en_nxt_s;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .CLK      (CLK),
        .RST      (RST),
        .start    (load),
        .value    (value),
        .busy     (conv_busy_s),
        .done     (conv_done_s),
        .bcd      (conv_bcd_s),
        .overflow (conv_ovf_s)
    );

    // Display register and overflow flag change together when a conversion ends.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            disp_r <= '0;
            ovf_r  <= 1'b0;
        end else if (conv_done_s) begin
            disp_r <= conv_bcd_s;
            ovf_r  <= conv_ovf_s;
        end
    end

    // Next prescaler / scan index; the index advances when the prescaler wraps.
    always_comb begin
        if (presc_r == PW'(SCAN_DIV - 1)) begin
            presc_nxt_s = '0;
            if (idx_r == IW'(DIGITS - 1)) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IW'(1);
            end
        end else begin
            presc_nxt_s = presc_r + PW'(1);
            idx_nxt_s   = idx_r;
        end
    end

    // Active-high pattern per digit: walk from the top digit down so each digit
    // knows whether any higher digit is non-zero (leading-zero blanking).
    always_comb begin
        nz_above_s = 1'b0;
        dig_val_s  = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig_val_s  = disp_r[4*i +: 4];
            nz_above_s = nz_above_s | (dig_val_s != 4'd0);
            if (ovf_r) begin
                pat_s[i] = SEG_DASH;
            end else if (blank_lz && (i != 0) && !nz_above_s) begin
                pat_s[i] = SEG_OFF;
            end else begin
                pat_s[i] = seg_lut(dig_val_s);
            end
            pat_s[i][SEG_DP_BIT] = dp[i];
        end
    end

    // Pick the pattern and one-hot select for the digit being shown next cycle,
    // then apply blanking and pin polarity.
    always_comb begin
        sel_pat_s = SEG_OFF;
        dig_sel_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt_s == IW'(i)) begin
                sel_pat_s    = pat_s[i];
                dig_sel_s[i] = 1'b1;
            end else begin
                dig_sel_s[i] = 1'b0;
            end
        end
        // The prescaler restarts at 0 on every index change, so its low counts
        // mark the anti-ghost window.
        if (presc_nxt_s < PW'(BLANK_CYC)) begin
            segs_nxt_s = SEG_PIN_OFF;
        end else if (SEG_ACTIVE_LOW != 0) begin
            segs_nxt_s = ~sel_pat_s;
        end else begin
            segs_nxt_s = sel_pat_s;
        end
        if (DIG_ACTIVE_LOW != 0) begin
            digit_en_nxt_s = ~dig_sel_s;
        end else begin
            digit_en_nxt_s = dig_sel_s;
        end
    end

    // Scan state and registered pin outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_r    <= '0;
            idx_r      <= '0;
            segs_r     <= SEG_PIN_OFF;
            digit_en_r <= DIG_PIN_OFF;
        end else begin
            presc_r    <= presc_nxt_s;
            idx_r      <= idx_nxt_s;
            segs_r     <= segs_nxt_s;
            digit_en_r <= digit_en_nxt_s;
        end
    end

    assign busy     = conv_busy_s;
    assign overflow = ovf_r;
    assign segs     = segs_r;
    assign digit_en = digit_en_r;

endmodule
